// File: rtl/fwd_pkg.sv
// Shared types and helpers for the EXE operand-forwarding / load-use hazard unit.
package fwd_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StStall = 1'b1
  } fwd_state_e;

  // Select code meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

  function automatic int unsigned sel_w(input int unsigned num_fwd);
    return $clog2(num_fwd + 1);
  endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Single-operand forwarding priority encoder: picks the youngest writeback stage
// whose destination matches the source register (r0 never forwards).
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned SEL_W   = sel_w(NUM_FWD)
) (
  input  logic [NUM_FWD-1:0]        reg_write_stg_i,
  input  logic [NUM_FWD*REG_AW-1:0] dst_reg_stg_i,
  input  logic [REG_AW-1:0]         src_i,
  output logic [SEL_W-1:0]          sel_o
);

  always_comb begin
    sel_o = SEL_W'(FWD_RF);
    if (src_i != '0) begin
      // Scan oldest to youngest so the lowest matching stage overwrites last.
      for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
        if (reg_write_stg_i[k] && (dst_reg_stg_i[k*REG_AW +: REG_AW] != '0) &&
            (dst_reg_stg_i[k*REG_AW +: REG_AW] == src_i)) begin
          sel_o = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EXE operand forwarding plus load-use stall FSM. Optional perf counters are
// enabled by defining FWD_PERF_CNT_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned SEL_W   = sel_w(NUM_FWD)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [NUM_FWD-1:0]        reg_write_stg_i,
  input  logic [NUM_FWD*REG_AW-1:0] dst_reg_stg_i,
  input  logic                      reg_write_exe_i,
  input  logic                      mem_read_exe_i,
  input  logic [REG_AW-1:0]         dst_reg_exe_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_exe_i,
  input  logic [NUM_SRC*REG_AW-1:0] src_id_i,
  input  logic [NUM_SRC-1:0]        src_used_id_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      stall_id_o,
  output logic                      bubble_exe_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cycles_o,
  output logic [CNT_W-1:0]          fwd_events_o
`endif
);

  localparam int unsigned CNT_LW = $clog2(LOAD_LAT + 1);
  localparam logic [CNT_LW-1:0] CntLoad = CNT_LW'(LOAD_LAT - 1);

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_src_match #(
      .REG_AW (REG_AW),
      .NUM_FWD(NUM_FWD),
      .SEL_W  (SEL_W)
    ) u_match (
      .reg_write_stg_i(reg_write_stg_i),
      .dst_reg_stg_i  (dst_reg_stg_i),
      .src_i          (src_exe_i[i*REG_AW +: REG_AW]),
      .sel_o          (fwd_sel_o[i*SEL_W +: SEL_W])
    );
  end

  logic src_hit;
  logic hazard;

  always_comb begin
    src_hit = 1'b0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (src_used_id_i[i] && (src_id_i[i*REG_AW +: REG_AW] == dst_reg_exe_i)) begin
        src_hit = 1'b1;
      end
    end
  end

  assign hazard = reg_write_exe_i & mem_read_exe_i & (dst_reg_exe_i != '0) & src_hit;

  fwd_state_e        state_q, state_d;
  logic [CNT_LW-1:0] cnt_q, cnt_d;
  logic              stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    if (flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hazard) begin
            stall = 1'b1;
            // First stall cycle is spent here; the rest are counted in StStall.
            if (LOAD_LAT > 1) begin
              state_d = StStall;
              cnt_d   = CntLoad;
            end
          end
        end
        StStall: begin
          stall = 1'b1;
          if (cnt_q == CNT_LW'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_LW'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_id_o   = stall;
  assign bubble_exe_o = stall;

`ifdef FWD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] fwd_events_q, fwd_events_d;
  logic [CNT_W:0]   fwd_n, stall_sum, fwd_sum;

  // Sums are one bit wider so a carry out means the counter should pin at all-ones.
  always_comb begin
    fwd_n = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      if (fwd_sel_o[i*SEL_W +: SEL_W] != '0) fwd_n = fwd_n + (CNT_W + 1)'(1);
    end
    stall_sum      = {1'b0, stall_cycles_q} + {{CNT_W{1'b0}}, stall};
    fwd_sum        = {1'b0, fwd_events_q} + fwd_n;
    stall_cycles_d = stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
    fwd_events_d   = fwd_sum[CNT_W] ? '1 : fwd_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_events_q   <= fwd_events_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign fwd_events_o   = fwd_events_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: one instance with LOAD_LAT=1, one with LOAD_LAT=3.
module tb_fwd_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [1:0] reg_write_stg;
  logic [9:0] dst_reg_stg;
  logic       reg_write_exe;
  logic       mem_read_exe;
  logic [4:0] dst_reg_exe;
  logic [9:0] src_exe;
  logic [9:0] src_id;
  logic [1:0] src_used_id;

  logic [3:0] fwd_sel1, fwd_sel3;
  logic       stall1, bubble1, stall3, bubble3;
`ifdef FWD_PERF_CNT_EN
  logic [15:0] sc1, fe1;
  logic [1:0]  sc3, fe3;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(
    .LOAD_LAT(1)
  ) dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .reg_write_stg_i(reg_write_stg),
    .dst_reg_stg_i  (dst_reg_stg),
    .reg_write_exe_i(reg_write_exe),
    .mem_read_exe_i (mem_read_exe),
    .dst_reg_exe_i  (dst_reg_exe),
    .src_exe_i      (src_exe),
    .src_id_i       (src_id),
    .src_used_id_i  (src_used_id),
    .fwd_sel_o      (fwd_sel1),
    .stall_id_o     (stall1),
    .bubble_exe_o   (bubble1)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cycles_o (sc1),
    .fwd_events_o   (fe1)
`endif
  );

  fwd_hazard_unit #(
    .LOAD_LAT(3),
    .CNT_W   (2)
  ) dut3 (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .reg_write_stg_i(reg_write_stg),
    .dst_reg_stg_i  (dst_reg_stg),
    .reg_write_exe_i(reg_write_exe),
    .mem_read_exe_i (mem_read_exe),
    .dst_reg_exe_i  (dst_reg_exe),
    .src_exe_i      (src_exe),
    .src_id_i       (src_id),
    .src_used_id_i  (src_used_id),
    .fwd_sel_o      (fwd_sel3),
    .stall_id_o     (stall3),
    .bubble_exe_o   (bubble3)
`ifdef FWD_PERF_CNT_EN
    ,
    .stall_cycles_o (sc3),
    .fwd_events_o   (fe3)
`endif
  );

  task automatic clear_hz();
    flush         = 1'b0;
    reg_write_exe = 1'b0;
    mem_read_exe  = 1'b0;
    dst_reg_exe   = 5'd0;
    src_id        = 10'd0;
    src_used_id   = 2'b00;
  endtask

  // Load into r5 in EXE, ID reads the given sources.
  task automatic set_hz(input logic [1:0] used, input logic [9:0] sid);
    reg_write_exe = 1'b1;
    mem_read_exe  = 1'b1;
    dst_reg_exe   = 5'd5;
    src_id        = sid;
    src_used_id   = used;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_hz();
    reg_write_stg = 2'b00;
    dst_reg_stg   = 10'd0;
    src_exe       = 10'd0;
    #1;
    n_checks++;
    if ({stall1, bubble1, stall3, bubble3} !== 4'b0000)
      $display("FAIL reset_stall got %b want 0000", {stall1, bubble1, stall3, bubble3});
    else n_pass++;
    n_checks++;
    if ({fwd_sel1, fwd_sel3} !== 8'h00)
      $display("FAIL reset_fwd got %h want 00", {fwd_sel1, fwd_sel3});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_priority();
    @(negedge clk);
    src_exe       = {5'd3, 5'd3};
    dst_reg_stg   = {5'd3, 5'd3};
    reg_write_stg = 2'b11;
    #1;
    n_checks++;
    if (fwd_sel1 !== 4'b0101) $display("FAIL fwd_both_mem got %b want 0101", fwd_sel1);
    else n_pass++;
    n_checks++;
    if (fwd_sel3 !== 4'b0101) $display("FAIL fwd_both_mem_d3 got %b want 0101", fwd_sel3);
    else n_pass++;
    reg_write_stg = 2'b10;
    #1;
    n_checks++;
    if (fwd_sel1 !== 4'b1010) $display("FAIL fwd_both_wb got %b want 1010", fwd_sel1);
    else n_pass++;
    src_exe       = {5'd7, 5'd3};
    dst_reg_stg   = {5'd3, 5'd7};
    reg_write_stg = 2'b11;
    #1;
    n_checks++;
    if (fwd_sel1 !== 4'b0110) $display("FAIL fwd_split got %b want 0110", fwd_sel1);
    else n_pass++;
    reg_write_stg = 2'b01;
    #1;
    n_checks++;
    if (fwd_sel1 !== 4'b0100) $display("FAIL fwd_mem_only got %b want 0100", fwd_sel1);
    else n_pass++;
  endtask

  task automatic test_reg0();
    @(negedge clk);
    src_exe       = 10'd0;
    dst_reg_stg   = 10'd0;
    reg_write_stg = 2'b11;
    #1;
    n_checks++;
    if (fwd_sel1 !== 4'b0000) $display("FAIL fwd_r0 got %b want 0000", fwd_sel1);
    else n_pass++;
    reg_write_stg = 2'b00;
    reg_write_exe = 1'b1;
    mem_read_exe  = 1'b1;
    dst_reg_exe   = 5'd0;
    src_id        = 10'd0;
    src_used_id   = 2'b11;
    #1;
    n_checks++;
    if ({stall1, stall3} !== 2'b00) $display("FAIL load_r0 got %b want 00", {stall1, stall3});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({stall1, stall3} !== 2'b00) $display("FAIL load_r0_next got %b want 00", {stall1, stall3});
    else n_pass++;
    clear_hz();
  endtask

  task automatic test_load_lat1();
    @(negedge clk);
    set_hz(2'b10, {5'd5, 5'd0});
    #1;
    n_checks++;
    if ({stall1, bubble1, stall3, bubble3} !== 4'b1111)
      $display("FAIL haz_op1_c1 got %b want 1111", {stall1, bubble1, stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    clear_hz();
    #1;
    n_checks++;
    if ({stall1, bubble1, stall3, bubble3} !== 4'b0011)
      $display("FAIL haz_op1_c2 got %b want 0011", {stall1, bubble1, stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({stall3, bubble3} !== 2'b11) $display("FAIL lat3_c3 got %b want 11", {stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({stall3, bubble3} !== 2'b00) $display("FAIL lat3_c4 got %b want 00", {stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    set_hz(2'b01, {5'd0, 5'd5});
    #1;
    n_checks++;
    if ({stall1, bubble1} !== 2'b11) $display("FAIL haz_op0 got %b want 11", {stall1, bubble1});
    else n_pass++;
    @(negedge clk);
    clear_hz();
    @(negedge clk);
    @(negedge clk);
    set_hz(2'b00, {5'd5, 5'd5});
    #1;
    n_checks++;
    if ({stall1, stall3} !== 2'b00) $display("FAIL unused_src got %b want 00", {stall1, stall3});
    else n_pass++;
    src_used_id  = 2'b11;
    mem_read_exe = 1'b0;
    #1;
    n_checks++;
    if ({stall1, stall3} !== 2'b00) $display("FAIL not_load got %b want 00", {stall1, stall3});
    else n_pass++;
    clear_hz();
  endtask

  task automatic test_lat3_held();
    @(negedge clk);
    set_hz(2'b10, {5'd5, 5'd0});
    #1;
    n_checks++;
    if ({stall3, bubble3} !== 2'b11) $display("FAIL held_c1 got %b want 11", {stall3, bubble3});
    else n_pass++;
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if ({stall1, stall3, bubble3} !== 3'b111)
        $display("FAIL held_c%0d got %b want 111", c, {stall1, stall3, bubble3});
      else n_pass++;
    end
    @(negedge clk);
    clear_hz();
    #1;
    n_checks++;
    if ({stall1, stall3, bubble3} !== 3'b000)
      $display("FAIL held_c4 got %b want 000", {stall1, stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (stall3 !== 1'b0) $display("FAIL held_c5 got %b want 0", stall3);
    else n_pass++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    set_hz(2'b10, {5'd5, 5'd0});
    #1;
    n_checks++;
    if (stall3 !== 1'b1) $display("FAIL flush_pre got %b want 1", stall3);
    else n_pass++;
    @(negedge clk);
    clear_hz();
    flush = 1'b1;
    #1;
    n_checks++;
    if ({stall3, bubble3} !== 2'b00) $display("FAIL flush_mid got %b want 00", {stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if ({stall3, bubble3} !== 2'b00) $display("FAIL flush_after got %b want 00", {stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    set_hz(2'b10, {5'd5, 5'd0});
    flush = 1'b1;
    #1;
    n_checks++;
    if ({stall1, bubble1, stall3, bubble3} !== 4'b0000)
      $display("FAIL flush_detect got %b want 0000", {stall1, bubble1, stall3, bubble3});
    else n_pass++;
    @(negedge clk);
    clear_hz();
    #1;
    n_checks++;
    if (stall3 !== 1'b0) $display("FAIL flush_detect_next got %b want 0", stall3);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    reg_write_stg = 2'b00;
    src_exe       = 10'd0;
    @(negedge clk);
    set_hz(2'b10, {5'd5, 5'd0});
    @(negedge clk);
    clear_hz();
    #1;
    n_checks++;
    if (stall3 !== 1'b1) $display("FAIL arst_pre got %b want 1", stall3);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({stall3, bubble3} !== 2'b00) $display("FAIL arst_drop got %b want 00", {stall3, bubble3});
    else n_pass++;
    n_checks++;
    if ({fwd_sel1, fwd_sel3} !== 8'h00)
      $display("FAIL arst_fwd got %h want 00", {fwd_sel1, fwd_sel3});
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (stall3 !== 1'b0) $display("FAIL arst_after got %b want 0", stall3);
    else n_pass++;
  endtask

`ifdef FWD_PERF_CNT_EN
  task automatic test_perf();
    n_checks++;
    if ({sc3, fe3} !== 4'h0) $display("FAIL perf_reset got %h want 0", {sc3, fe3});
    else n_pass++;
    for (int s = 1; s <= 2; s++) begin
      @(negedge clk);
      set_hz(2'b10, {5'd5, 5'd0});
      @(negedge clk);
      clear_hz();
      @(negedge clk);
      @(negedge clk);
      #1;
      n_checks++;
      if (sc3 !== 2'd3) $display("FAIL perf_stall3_%0d got %0d want 3", s, sc3);
      else n_pass++;
      n_checks++;
      if (sc1 !== 16'(s)) $display("FAIL perf_stall1_%0d got %0d want %0d", s, sc1, s);
      else n_pass++;
    end
    @(negedge clk);
    src_exe       = {5'd3, 5'd3};
    dst_reg_stg   = {5'd3, 5'd3};
    reg_write_stg = 2'b11;
    @(negedge clk);
    #1;
    n_checks++;
    if ({fe1, fe3} !== {16'd2, 2'd2}) $display("FAIL perf_fwd1 got %0d/%0d want 2/2", fe1, fe3);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if ({fe1, fe3} !== {16'd4, 2'd3}) $display("FAIL perf_fwd2 got %0d/%0d want 4/3", fe1, fe3);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_fwd_priority();
    test_reg0();
    test_load_lat1();
    test_lat3_held();
    test_flush();
    test_async_reset();
`ifdef FWD_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
